pir_display_driver: RTL
=======================

// Module: pir_display_driver
// PURPOSE
//  Reader/consumer of the PIR controller's 21-bit display_data status word. Snapshots the word and
//  converts the 8-bit peak level to BCD with a sequential shift-add-3 engine. Drives a
//  time-multiplexed 5-digit 7-segment display: trigger count, sensor id, and peak hundreds/tens/units.
//  Sits between the PIR controller and the board display pins.
// PARAMETERS
//  REFRESH_DIV  1000  clk cycles each digit stays lit; legal range 2..65535
//  BLANK_ZEROS  1     1: blank leading zeros of peak hundreds/tens; 0: show them
// PORTS
//  clk           in   1   system clock, all logic on posedge
//  rst           in   1   synchronous reset, active-high
//  display_data  in   21  [3:0]=sensors triggered, [11:4]=peak level, [15:12]=sensor id, [20:16] ignored
//  seg           out  7   segments {g,f,e,d,c,b,a}, active-high, registered
//  an            out  5   one-hot digit enable, active-high, registered; bit0=count, 1=id, 2=units, 3=tens, 4=hundreds
//  busy          out  1   high while a BCD conversion is in progress
// BEHAVIOUR
//  Reset (rst=1 at posedge): seg=0, an=0, busy=0; snapshot, BCD regs, refresh counter, digit index and shift
//   counter=0; FSM=IDLE. Reset mid-conversion aborts it; no partial result is committed.
//  FSM, one transition per clk:
//   IDLE : if display_data[15:0] != snapshot -> snapshot<=display_data[15:0], load shift reg {12'b0, peak},
//          busy<=1, go SHIFT; else stay.
//   SHIFT: 8 cycles; each cycle add 3 to every BCD nibble >=5, then shift left 1. After the 8th, go DONE.
//   DONE : commit hundreds/tens/units and snapshot's count/id to display regs, busy<=0, go IDLE.
//  Latency: input change sampled at edge N -> display regs updated at edge N+9 -> seg reflects at N+10.
//  Input changes during SHIFT/DONE are ignored; IDLE re-compares and reconverts. Last value always wins.
//  Displayed count/id/peak always come from one snapshot; no mixed frames.
//  Scan: 16-bit refresh counter increments every cycle; at REFRESH_DIV-1 it wraps to 0 and digit index
//   advances 0->1->2->3->4->0. an=1<<index; seg=glyph(selected digit), both registered (1-cycle delay).
//   First cycle after reset release: an=5'b00001.
//  Glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; blank=00; error 'E'=79.
//  Count or id nibble >9 -> 'E'. Peak 0..255 always valid BCD.
//  BLANK_ZEROS=1: hundreds blank if 0; tens blank if hundreds=0 and tens=0; units never blank.
//  Conversion commit and digit advance on the same edge: both take effect; seg shows the new value next cycle.
// TESTING
//  1 rst high 3 cycles, display_data=0 -> seg=00, an=00, busy=0; after release an=00001, seg=3F, busy stays 0.
//  2 display_data[11:4]=127 -> busy high 9 cycles; digits 4/3/2 = 06/5B/07.
//  3 REFRESH_DIV=4, static input -> an steps 00001,00010,00100,01000,10000,00001 every 4 cycles.
//  4 count=4'hA, id=2 -> digit0=79, digit1=5B; peak=5 with BLANK_ZEROS=1 -> digits4/3=00, digit2=6D.
//  5 peak 127 then 200 two cycles later, mid-SHIFT -> 127 commits first, 200 converts next; final 5B/3F/3F.
//  6 rst asserted mid-SHIFT -> busy=0, display regs=0; no 127 digits appear after release.

Source files
------------

// File: rtl/pir_display_driver.sv
// Snapshots the PIR status word, converts the peak level to BCD with a serial
// shift-add-3 engine, and scans a 5-digit multiplexed 7-segment display.
module pir_display_driver #(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          BLANK_ZEROS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [20:0] display_data,
    output logic [6:0]  seg,
    output logic [4:0]  an,
    output logic        busy
);

    localparam int unsigned REF_W   = 16;
    localparam int unsigned SHIFT_W = 20;
    localparam int unsigned DIGITS  = 5;
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [15:0]         r_snap;
    logic [SHIFT_W-1:0]  r_shift;
    logic [2:0]          r_bits;
    logic [REF_W-1:0]    r_refresh;
    logic [2:0]          r_idx;
    logic [3:0]          r_disp_cnt;
    logic [3:0]          r_disp_id;
    logic [3:0]          r_disp_h;
    logic [3:0]          r_disp_t;
    logic [3:0]          r_disp_u;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_busy;

    logic [3:0]          w_nib;
    logic                w_blank;
    logic [6:0]          w_seg;
    logic                w_unused;

    assign w_unused = ^display_data[20:16];

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = 7'h79;
        endcase
        return g;
    endfunction

    // One double-dabble iteration: correct each BCD nibble, then shift left.
    function automatic logic [SHIFT_W-1:0] bcd_step(input logic [SHIFT_W-1:0] s);
        logic [SHIFT_W-1:0] t;
        t = s;
        for (int k = 0; k < 3; k++) begin
            if (t[8 + 4*k +: 4] >= 4'd5) begin
                t[8 + 4*k +: 4] = t[8 + 4*k +: 4] + 4'd3;
            end
        end
        return {t[SHIFT_W-2:0], 1'b0};
    endfunction

    // Digit select with leading-zero blanking on the peak hundreds/tens.
    always_comb begin
        w_nib   = 4'd0;
        w_blank = 1'b0;
        case (r_idx)
            3'd0: w_nib = r_disp_cnt;
            3'd1: w_nib = r_disp_id;
            3'd2: w_nib = r_disp_u;
            3'd3: begin
                w_nib   = r_disp_t;
                w_blank = BLANK_ZEROS && (r_disp_h == 4'd0) && (r_disp_t == 4'd0);
            end
            3'd4: begin
                w_nib   = r_disp_h;
                w_blank = BLANK_ZEROS && (r_disp_h == 4'd0);
            end
            default: w_blank = 1'b1;
        endcase
        w_seg = w_blank ? 7'h00 : glyph(w_nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_snap     <= 16'd0;
            r_shift    <= '0;
            r_bits     <= 3'd0;
            r_refresh  <= '0;
            r_idx      <= 3'd0;
            r_disp_cnt <= 4'd0;
            r_disp_id  <= 4'd0;
            r_disp_h   <= 4'd0;
            r_disp_t   <= 4'd0;
            r_disp_u   <= 4'd0;
            r_seg      <= 7'h00;
            r_an       <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (r_refresh == REF_MAX) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_refresh <= r_refresh + REF_W'(1);
            end
            r_an  <= DIGITS'(1) << r_idx;
            r_seg <= w_seg;

            case (r_state)
                S_IDLE: begin
                    if (display_data[15:0] != r_snap) begin
                        r_snap  <= display_data[15:0];
                        r_shift <= {12'd0, display_data[11:4]};
                        r_bits  <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shift <= bcd_step(r_shift);
                    r_bits  <= r_bits + 3'd1;
                    if (r_bits == 3'd7) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_disp_h   <= r_shift[19:16];
                    r_disp_t   <= r_shift[15:12];
                    r_disp_u   <= r_shift[11:8];
                    r_disp_cnt <= r_snap[3:0];
                    r_disp_id  <= r_snap[15:12];
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign busy = r_busy;

endmodule
